// File: rtl/clint_axi_pkg.sv
// Shared constants for the CLINT AXI initiator:
// FSM encodings, AXI field values and CLINT register offsets.
package clint_axi_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_AR   = 3'd3;
  localparam logic [2:0] ST_R    = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] CACHE_MOD   = 4'b0010;

  localparam logic [63:0] MSIP_OFF     = 64'h0;
  localparam logic [63:0] MTIMECMP_OFF = 64'h4000;
  localparam logic [63:0] MTIME_OFF    = 64'hBFF8;

endpackage

// File: rtl/clint_axi_initiator_if.sv
// AXI4 bus between the CLINT initiator (master)
// and the CLINT register slave.
interface clint_axi_initiator_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 4
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awqos,
    output awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos,
    output arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awqos,
    input  awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos,
    input  arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

endinterface

// File: rtl/clint_axi_initiator.sv
// Single-outstanding AXI4 master turning a register
// request into one single-beat CLINT read or write.
module clint_axi_initiator
  import clint_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  clint_axi_initiator_if.master   axi
);

  localparam logic [2:0] SIZE =
    3'($clog2(DATA_WIDTH/8));

  logic [2:0]              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strb;
  logic aw_valid, w_valid, ar_valid;
  logic b_ready, r_ready;
  logic aw_fin, w_fin;
  logic unused_user;

  assign axi.awid     = AXI_ID;
  assign axi.awaddr   = addr;
  assign axi.awlen    = 8'd0;
  assign axi.awsize   = SIZE;
  assign axi.awburst  = BURST_INCR;
  assign axi.awlock   = 1'b0;
  assign axi.awcache  = CACHE_MOD;
  assign axi.awprot   = 3'd0;
  assign axi.awqos    = 4'd0;
  assign axi.awregion = 4'd0;
  assign axi.awuser   = '0;
  assign axi.awvalid  = aw_valid;

  assign axi.wdata  = wdata;
  assign axi.wstrb  = strb;
  assign axi.wlast  = 1'b1;
  assign axi.wuser  = '0;
  assign axi.wvalid = w_valid;
  assign axi.bready = b_ready;

  assign axi.arid     = AXI_ID;
  assign axi.araddr   = addr;
  assign axi.arlen    = 8'd0;
  assign axi.arsize   = SIZE;
  assign axi.arburst  = BURST_INCR;
  assign axi.arlock   = 1'b0;
  assign axi.arcache  = CACHE_MOD;
  assign axi.arprot   = 3'd0;
  assign axi.arqos    = 4'd0;
  assign axi.arregion = 4'd0;
  assign axi.aruser   = '0;
  assign axi.arvalid  = ar_valid;
  assign axi.rready   = r_ready;

  assign unused_user = ^{axi.buser, axi.ruser};

  // a channel is finished once its valid has dropped
  // or it handshakes in the current cycle
  assign aw_fin = !aw_valid || axi.awready;
  assign w_fin  = !w_valid  || axi.wready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      strb        <= '0;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      ar_valid    <= 1'b0;
      b_ready     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            addr        <= req_addr_i;
            wdata       <= req_wdata_i;
            strb        <= req_be_i;
            if (req_we_i) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= ST_WR;
            end else begin
              ar_valid <= 1'b1;
              state    <= ST_AR;
            end
          end
        end
        ST_WR: begin
          if (axi.awready) aw_valid <= 1'b0;
          if (axi.wready)  w_valid  <= 1'b0;
          if (aw_fin && w_fin) begin
            b_ready <= 1'b1;
            state   <= ST_B;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            b_ready     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= (axi.bresp != RESP_OKAY)
                        || (axi.bid != AXI_ID);
            state       <= ST_RESP;
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            r_ready     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= axi.rdata;
            rsp_err_o   <= (axi.rresp != RESP_OKAY)
                        || (axi.rid != AXI_ID)
                        || !axi.rlast;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_axi_initiator.sv
// Directed bench for clint_axi_initiator with a
// hand-driven AXI slave and protocol assertions.
module tb_clint_axi_initiator;
  import clint_axi_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0;
  int w_hs  = 0;
  int ar_hs = 0;

  clint_axi_initiator_if axi_bus ();

  clint_axi_initiator dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .axi         (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi_bus.awvalid && axi_bus.awready) aw_hs++;
    if (axi_bus.wvalid && axi_bus.wready)   w_hs++;
    if (axi_bus.arvalid && axi_bus.arready) ar_hs++;
  end

  a_aw_hold: assert property (@(posedge clk)
    disable iff (rst)
    axi_bus.awvalid && !axi_bus.awready |=>
      axi_bus.awvalid && $stable(axi_bus.awaddr));
  a_w_hold: assert property (@(posedge clk)
    disable iff (rst)
    axi_bus.wvalid && !axi_bus.wready |=>
      axi_bus.wvalid && $stable(axi_bus.wdata)
      && $stable(axi_bus.wstrb));
  a_ar_hold: assert property (@(posedge clk)
    disable iff (rst)
    axi_bus.arvalid && !axi_bus.arready |=>
      axi_bus.arvalid && $stable(axi_bus.araddr));
  a_one_txn: assert property (@(posedge clk)
    !(axi_bus.arvalid && (axi_bus.awvalid
      || axi_bus.wvalid || axi_bus.bready)));
  a_wlast: assert property (@(posedge clk)
    axi_bus.wvalid |-> axi_bus.wlast);

  // called on a negedge with the DUT idle; returns on
  // the negedge after the request was accepted
  task automatic issue(input logic we,
                       input logic [63:0] a,
                       input logic [63:0] d,
                       input logic [7:0] be);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100",
        {req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %0h expected 0",
        rsp_rdata);
    end
    checks++;
    if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
         axi_bus.bready, axi_bus.rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 00000",
        {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
         axi_bus.bready, axi_bus.rready});
    end
  endtask

  task automatic test_write;
    int aw0 = aw_hs;
    int w0  = w_hs;
    issue(1'b1, MTIMECMP_OFF, 64'h10, 8'hFF);
    checks++;
    if ({axi_bus.awvalid, axi_bus.wvalid, req_ready}
        !== 3'b110) begin
      errors++;
      $display("FAIL wr_valids: got %b expected 110",
        {axi_bus.awvalid, axi_bus.wvalid, req_ready});
    end
    checks++;
    if (axi_bus.awaddr !== 64'h4000) begin
      errors++;
      $display("FAIL wr_addr: got %0h expected 4000",
        axi_bus.awaddr);
    end
    checks++;
    if ({axi_bus.awlen, axi_bus.awsize, axi_bus.awburst,
         axi_bus.awcache} !== {8'd0, 3'd3, 2'b01, 4'b0010})
    begin
      errors++;
      $display("FAIL wr_fields: got %0h expected %0h",
        {axi_bus.awlen, axi_bus.awsize, axi_bus.awburst,
         axi_bus.awcache}, {8'd0, 3'd3, 2'b01, 4'b0010});
    end
    checks++;
    if ({axi_bus.wdata, axi_bus.wstrb, axi_bus.wlast}
        !== {64'h10, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL wr_wbeat: got %0h expected %0h",
        {axi_bus.wdata, axi_bus.wstrb, axi_bus.wlast},
        {64'h10, 8'hFF, 1'b1});
    end
    axi_bus.awready = 1'b1;
    axi_bus.wready  = 1'b1;
    @(negedge clk);
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    checks++;
    if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}
        !== 3'b001) begin
      errors++;
      $display("FAIL wr_bready: got %b expected 001",
        {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready});
    end
    axi_bus.bvalid = 1'b1;
    axi_bus.bresp  = RESP_OKAY;
    axi_bus.bid    = 4'h0;
    @(negedge clk);
    axi_bus.bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, axi_bus.bready} !== 3'b100)
    begin
      errors++;
      $display("FAIL wr_rsp: got %b expected 100",
        {rsp_valid, rsp_err, axi_bus.bready});
    end
    checks++;
    if (rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL wr_rdata: got %0h expected 0",
        rsp_rdata);
    end
    checks++;
    if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin
      errors++;
      $display("FAIL wr_beats: got aw %0d w %0d expected 1 1",
        aw_hs - aw0, w_hs - w0);
    end
    consume();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_done: got %b expected 01",
        {rsp_valid, req_ready});
    end
  endtask

  task automatic test_read;
    issue(1'b0, MTIME_OFF, 64'h0, 8'h0);
    checks++;
    if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}
        !== 3'b001) begin
      errors++;
      $display("FAIL rd_valids: got %b expected 001",
        {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid});
    end
    checks++;
    if ({axi_bus.araddr, axi_bus.arlen, axi_bus.arsize,
         axi_bus.arburst} !== {64'hBFF8, 8'd0, 3'd3, 2'b01})
    begin
      errors++;
      $display("FAIL rd_ar: got %0h expected %0h",
        {axi_bus.araddr, axi_bus.arlen, axi_bus.arsize,
         axi_bus.arburst}, {64'hBFF8, 8'd0, 3'd3, 2'b01});
    end
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    checks++;
    if ({axi_bus.arvalid, axi_bus.rready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_rready: got %b expected 01",
        {axi_bus.arvalid, axi_bus.rready});
    end
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = 64'h1234;
    axi_bus.rresp  = RESP_OKAY;
    axi_bus.rid    = 4'h0;
    axi_bus.rlast  = 1'b1;
    @(negedge clk);
    axi_bus.rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10
        || rsp_rdata !== 64'h1234) begin
      errors++;
      $display("FAIL rd_rsp: got v%b e%b d%0h expected v1 e0 d1234",
        rsp_valid, rsp_err, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_backpressure;
    int aw0 = aw_hs;
    int w0  = w_hs;
    issue(1'b1, MSIP_OFF, 64'h1, 8'h0F);
    checks++;
    if (axi_bus.wstrb !== 8'h0F) begin
      errors++;
      $display("FAIL bp_strb: got %0h expected 0f",
        axi_bus.wstrb);
    end
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({axi_bus.awvalid, axi_bus.wvalid}
          !== {c <= 5, c <= 2}) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %b expected %b", c,
          {axi_bus.awvalid, axi_bus.wvalid},
          {c <= 5, c <= 2});
      end
      axi_bus.wready  = (c == 2);
      axi_bus.awready = (c == 5);
      @(negedge clk);
    end
    checks++;
    if (axi_bus.bready !== 1'b1
        || (aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin
      errors++;
      $display("FAIL bp_done: got b%b aw%0d w%0d expected b1 aw1 w1",
        axi_bus.bready, aw_hs - aw0, w_hs - w0);
    end
    axi_bus.bvalid = 1'b1;
    axi_bus.bresp  = RESP_OKAY;
    @(negedge clk);
    axi_bus.bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      errors++;
      $display("FAIL bp_rsp: got %b expected 10",
        {rsp_valid, rsp_err});
    end
    consume();
  endtask

  task automatic test_errors;
    issue(1'b1, MTIMECMP_OFF, 64'h5, 8'hFF);
    axi_bus.awready = 1'b1;
    axi_bus.wready  = 1'b1;
    @(negedge clk);
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    axi_bus.bvalid  = 1'b1;
    axi_bus.bresp   = RESP_SLVERR;
    @(negedge clk);
    axi_bus.bvalid  = 1'b0;
    axi_bus.bresp   = RESP_OKAY;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin
      errors++;
      $display("FAIL err_bresp: got %b expected 11",
        {rsp_valid, rsp_err});
    end
    consume();

    issue(1'b0, MTIME_OFF, 64'h0, 8'h0);
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rid     = 4'h3;
    axi_bus.rdata   = 64'hABCD;
    axi_bus.rlast   = 1'b1;
    @(negedge clk);
    axi_bus.rvalid  = 1'b0;
    axi_bus.rid     = 4'h0;
    req_we    = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid, rsp_err, req_ready} !== 3'b110
          || rsp_rdata !== 64'hABCD
          || axi_bus.arvalid !== 1'b0) begin
        errors++;
        $display("FAIL err_hold%0d: got v%b e%b rdy%b d%0h ar%b expected v1 e1 rdy0 dabcd ar0",
          c, rsp_valid, rsp_err, req_ready, rsp_rdata,
          axi_bus.arvalid);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    consume();

    issue(1'b0, MTIME_OFF, 64'h0, 8'h0);
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rlast   = 1'b0;
    @(negedge clk);
    axi_bus.rvalid  = 1'b0;
    axi_bus.rlast   = 1'b1;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin
      errors++;
      $display("FAIL err_rlast: got %b expected 11",
        {rsp_valid, rsp_err});
    end
    consume();
  endtask

  task automatic test_reset_mid;
    issue(1'b0, MTIME_OFF, 64'h0, 8'h0);
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    checks++;
    if (axi_bus.rready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got %b expected 1",
        axi_bus.rready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
         axi_bus.bready, axi_bus.rready, req_ready, rsp_valid}
        !== 7'b0000010) begin
      errors++;
      $display("FAIL rst_mid: got %b expected 0000010",
        {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
         axi_bus.bready, axi_bus.rready, req_ready,
         rsp_valid});
    end
    axi_bus.bvalid = 1'b1;
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = 64'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({axi_bus.bready, axi_bus.rready, rsp_valid,
           req_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL stray%0d: got %b expected 0001", c,
          {axi_bus.bready, axi_bus.rready, rsp_valid,
           req_ready});
      end
    end
    axi_bus.bvalid = 1'b0;
    axi_bus.rvalid = 1'b0;
    issue(1'b0, MTIME_OFF, 64'h0, 8'h0);
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rdata   = 64'h55;
    @(negedge clk);
    axi_bus.rvalid  = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10
        || rsp_rdata !== 64'h55) begin
      errors++;
      $display("FAIL rst_after: got v%b e%b d%0h expected v1 e0 d55",
        rsp_valid, rsp_err, rsp_rdata);
    end
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    axi_bus.arready = 1'b0;
    axi_bus.bid     = '0;
    axi_bus.bresp   = RESP_OKAY;
    axi_bus.buser   = '0;
    axi_bus.bvalid  = 1'b0;
    axi_bus.rid     = '0;
    axi_bus.rdata   = '0;
    axi_bus.rresp   = RESP_OKAY;
    axi_bus.rlast   = 1'b1;
    axi_bus.ruser   = '0;
    axi_bus.rvalid  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write();
    test_read();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
